// File: rtl/hazard_ctrl_mc_pkg.sv
// Shared encodings for the hazard controller: forwarding selects,
// the load result-source code and the multi-cycle FSM state type.
package hazard_pkg;

    // Operand-mux selects driven to the EX stage
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // resultSrc_E value that marks a load in EX
    localparam logic [1:0] RES_SRC_LOAD = 2'b01;

    // Occupancy timer width; covers MC_LAT-2 for MC_LAT up to 15
    localparam int MC_TW = 4;

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_t;

endpackage

// File: rtl/hazard_mc_timer.sv
// Multi-cycle execute occupancy timer. A start in IDLE raises busy in the
// same cycle and loads MC_LAT-2; busy then stays high while the count is
// non-zero. The zero-count cycle is the release cycle. freeze (data-memory
// wait) holds both the count and the state, so the release cycle itself is
// also held and a still-asserted start cannot retrigger while EX is frozen.
module hazard_mc_timer
    import hazard_pkg::*;
#(
    parameter int MC_LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic freeze,
    output logic busy
);

    mc_state_t        state_q, state_d;
    logic [MC_TW-1:0] timer_q, timer_d;

    // State and down-counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= MC_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Next-state, count and busy decode
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        busy    = 1'b0;
        unique case (state_q)
            MC_IDLE: begin
                if (start && !freeze) begin
                    busy    = 1'b1;
                    timer_d = MC_TW'(MC_LAT - 2);
                    state_d = MC_BUSY;
                end
            end
            MC_BUSY: begin
                if (timer_q != '0) begin
                    busy = 1'b1;
                    if (!freeze) begin
                        timer_d = timer_q - 1'b1;
                    end
                end else if (!freeze) begin
                    state_d = MC_IDLE;
                end
            end
            default: begin
                state_d = MC_IDLE;
                timer_d = '0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard controller for the 5-stage RV32I core: x0-aware operand
// forwarding, load-use and branch handling, multi-cycle execute stalls,
// data-memory wait stalls and a saturating stall-cycle counter.
module hazard_ctrl_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MC_LAT = 4,
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              regWrite_M,
    input  logic              regWrite_W,
    input  logic [REG_AW-1:0] rd_M,
    input  logic [REG_AW-1:0] rd_W,
    input  logic [REG_AW-1:0] rd_E,
    input  logic [REG_AW-1:0] rs1_D,
    input  logic [REG_AW-1:0] rs2_D,
    input  logic [REG_AW-1:0] rs1_E,
    input  logic [REG_AW-1:0] rs2_E,
    input  logic [1:0]        resultSrc_E,
    input  logic              PCSrc_E,
    input  logic              mcStart_E,
    input  logic              memOp_M,
    input  logic              dmemReady_M,
    input  logic              clrPerf,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              flushW,
    output logic              mcBusy,
    output logic [PERF_W-1:0] stallCycles
);

    logic mem_wait;
    logic load_use;
    logic mc_busy;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Forwarding select for one EX source; M beats W, x0 never forwards
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        if (regWrite_M && (rd_M != '0) && (rd_M == rs)) begin
            return FWD_M;
        end else if (regWrite_W && (rd_W != '0) && (rd_W == rs)) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

    assign mem_wait = memOp_M & ~dmemReady_M;
    assign load_use = (resultSrc_E == RES_SRC_LOAD) && (rd_E != '0) &&
                      ((rd_E == rs1_D) || (rd_E == rs2_D));

    hazard_mc_timer #(
        .MC_LAT (MC_LAT)
    ) u_mc_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mcStart_E),
        .freeze (mem_wait),
        .busy   (mc_busy)
    );

    // Forwarding and prioritised stall/flush decode; everything quiet in reset
    always_comb begin
        forwardAE = FWD_RF;
        forwardBE = FWD_RF;
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        stallM    = 1'b0;
        flushD    = 1'b0;
        flushE    = 1'b0;
        flushM    = 1'b0;
        flushW    = 1'b0;
        mcBusy    = 1'b0;
        if (rst_n) begin
            forwardAE = fwd_sel(rs1_E);
            forwardBE = fwd_sel(rs2_E);
            mcBusy    = mc_busy;
            if (mem_wait) begin
                // Whole front of the pipe waits on memory; WB gets a bubble
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                flushW = 1'b1;
            end else if (mc_busy) begin
                // Multi-cycle op holds EX; MEM receives bubbles meanwhile
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                flushM = 1'b1;
            end else if (PCSrc_E) begin
                // Taken branch discards the dependent instruction anyway
                flushD = 1'b1;
                flushE = 1'b1;
            end else if (load_use) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
        end
    end

    // Stall-cycle counter; clear beats increment
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stallCycles <= '0;
        end else if (clrPerf) begin
            stallCycles <= '0;
        end else if (stallF) begin
            stallCycles <= sat_inc(stallCycles);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed bench for hazard_ctrl_mc with a cycle-level reference model.
module tb_hazard_ctrl_mc;

    localparam int REG_AW = 5;
    localparam int MC_LAT = 4;
    localparam int PERF_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              regWrite_M, regWrite_W;
    logic [REG_AW-1:0] rd_M, rd_W, rd_E, rs1_D, rs2_D, rs1_E, rs2_E;
    logic [1:0]        resultSrc_E;
    logic              PCSrc_E, mcStart_E, memOp_M, dmemReady_M, clrPerf;
    logic [1:0]        forwardAE, forwardBE;
    logic              stallF, stallD, stallE, stallM;
    logic              flushD, flushE, flushM, flushW, mcBusy;
    logic [PERF_W-1:0] stallCycles;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    // Model state: EX occupancy cycles still owed by a multi-cycle op
    // (0 = none), and the expected counter value.
    int m_rem = 0;
    int m_cnt = 0;

    hazard_ctrl_mc #(
        .REG_AW (REG_AW),
        .MC_LAT (MC_LAT),
        .PERF_W (PERF_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .regWrite_M  (regWrite_M),
        .regWrite_W  (regWrite_W),
        .rd_M        (rd_M),
        .rd_W        (rd_W),
        .rd_E        (rd_E),
        .rs1_D       (rs1_D),
        .rs2_D       (rs2_D),
        .rs1_E       (rs1_E),
        .rs2_E       (rs2_E),
        .resultSrc_E (resultSrc_E),
        .PCSrc_E     (PCSrc_E),
        .mcStart_E   (mcStart_E),
        .memOp_M     (memOp_M),
        .dmemReady_M (dmemReady_M),
        .clrPerf     (clrPerf),
        .forwardAE   (forwardAE),
        .forwardBE   (forwardBE),
        .stallF      (stallF),
        .stallD      (stallD),
        .stallE      (stallE),
        .stallM      (stallM),
        .flushD      (flushD),
        .flushE      (flushE),
        .flushM      (flushM),
        .flushW      (flushW),
        .mcBusy      (mcBusy),
        .stallCycles (stallCycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_fwd(input logic [REG_AW-1:0] rs);
        if (!rst_n) return 2'b00;
        if (regWrite_M && rd_M != 0 && rd_M == rs) return 2'b10;
        if (regWrite_W && rd_W != 0 && rd_W == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Reference comparison on every falling edge
    always @(negedge clk) begin
        if (started) begin
            bit mw, lu, busy;
            bit sF, sD, sE, sM, fD, fE, fM, fW;
            int rem_now;
            mw = memOp_M && !dmemReady_M;
            lu = (resultSrc_E == 2'b01) && rd_E != 0 && (rd_E == rs1_D || rd_E == rs2_D);
            rem_now = m_rem;
            if (rem_now == 0 && mcStart_E && !mw) rem_now = MC_LAT;
            busy = rst_n && rem_now > 1;
            {sF, sD, sE, sM, fD, fE, fM, fW} = '0;
            if (rst_n) begin
                if (mw)            {sF, sD, sE, sM, fW} = 5'b11111;
                else if (busy)     {sF, sD, sE, fM} = 4'b1111;
                else if (PCSrc_E)  {fD, fE} = 2'b11;
                else if (lu)       {sF, sD, fE} = 3'b111;
            end
            check("forwardAE", forwardAE, model_fwd(rs1_E));
            check("forwardBE", forwardBE, model_fwd(rs2_E));
            check("stallF", stallF, sF);
            check("stallD", stallD, sD);
            check("stallE", stallE, sE);
            check("stallM", stallM, sM);
            check("flushD", flushD, fD);
            check("flushE", flushE, fE);
            check("flushM", flushM, fM);
            check("flushW", flushW, fW);
            check("mcBusy", mcBusy, busy);
            check("stallCycles", stallCycles, m_cnt);
            if (!rst_n) begin
                m_rem = 0;
                m_cnt = 0;
            end else begin
                if (!mw && rem_now > 0) m_rem = rem_now - 1;
                if (clrPerf) m_cnt = 0;
                else if (sF && m_cnt < (1 << PERF_W) - 1) m_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        regWrite_M = 0; regWrite_W = 0;
        rd_M = 0; rd_W = 0; rd_E = 0;
        rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0;
        resultSrc_E = 2'b00; PCSrc_E = 0; mcStart_E = 0;
        memOp_M = 0; dmemReady_M = 1; clrPerf = 0;
    endtask

    task automatic set_load_use();
        resultSrc_E = 2'b01; rd_E = 7; rs2_D = 7;
    endtask

    initial begin
        rst_n = 0;
        clr_in();
        step();
        started = 1;
        step();
        #1 check("rst_cnt", stallCycles, 0);
        check("rst_stallF", stallF, 0);
        rst_n = 1;
        step();

        // Forwarding: M wins, then W only, x0 ignored
        regWrite_M = 1; regWrite_W = 1; rd_M = 5; rd_W = 5; rs1_E = 5; rs2_E = 0;
        #1 check("fwdA_M", forwardAE, 2'b10);
        check("fwdB_none", forwardBE, 2'b00);
        step();
        rd_M = 0;
        #1 check("fwdB_x0", forwardBE, 2'b00);
        check("fwdA_W", forwardAE, 2'b01);

        // Load-use stall
        step(); clr_in(); set_load_use();
        #1 check("lu_stallF", stallF, 1);
        check("lu_stallD", stallD, 1);
        check("lu_flushE", flushE, 1);
        step(); clr_in();
        #1 check("lu_cnt", stallCycles, 1);
        resultSrc_E = 2'b01; rd_E = 0;
        #1 check("lu_x0_stallF", stallF, 0);
        check("lu_x0_flushE", flushE, 0);

        // Branch beats load-use
        step(); set_load_use(); PCSrc_E = 1;
        #1 check("br_flushD", flushD, 1);
        check("br_flushE", flushE, 1);
        check("br_stallF", stallF, 0);

        // Multi-cycle op, held start
        step(); clr_in(); mcStart_E = 1;
        #1 check("mc_t_busy", mcBusy, 1);
        check("mc_t_flushM", flushM, 1);
        step(); step();
        #1 check("mc_t2_busy", mcBusy, 1);
        step();
        #1 check("mc_rel_busy", mcBusy, 0);
        check("mc_rel_stallF", stallF, 0);
        step(); mcStart_E = 0;
        #1 check("mc_cnt", stallCycles, 4);

        // Multi-cycle op with two memory-wait cycles
        step(); mcStart_E = 1;
        #1 check("mw_t_busy", mcBusy, 1);
        step(); memOp_M = 1; dmemReady_M = 0;
        #1 check("mw_stallM", stallM, 1);
        check("mw_flushW", flushW, 1);
        check("mw_flushM", flushM, 0);
        step();
        step(); memOp_M = 0; dmemReady_M = 1;
        #1 check("mw_t3_busy", mcBusy, 1);
        step();
        step();
        #1 check("mw_rel_busy", mcBusy, 0);
        check("mw_rel_stallF", stallF, 0);
        step(); mcStart_E = 0;
        #1 check("mw_cnt", stallCycles, 9);

        // Reset in the middle of an op
        step(); mcStart_E = 1;
        step(); rst_n = 0;
        #1 check("rs_stallF", stallF, 0);
        check("rs_busy", mcBusy, 0);
        step(); rst_n = 1; mcStart_E = 0;
        #1 check("rs_after_stallF", stallF, 0);
        check("rs_after_busy", mcBusy, 0);
        check("rs_cnt", stallCycles, 0);

        // Clear wins over a coincident stall
        step(); set_load_use();
        step(); clrPerf = 1;
        #1 check("clr_pre", stallCycles, 1);
        step(); clr_in();
        #1 check("clr_win", stallCycles, 0);

        // Saturation of the counter
        memOp_M = 1; dmemReady_M = 0;
        repeat (20) step();
        memOp_M = 0; dmemReady_M = 1;
        #1 check("sat_cnt", stallCycles, 15);
        clrPerf = 1;
        step(); clrPerf = 0;
        #1 check("clr_only", stallCycles, 0);

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
